// File: rtl/ssrv_imem_wb_bridge.sv
// Fetch bridge: one 128-bit instruction-line request becomes BEATS pipelined
// Wishbone read beats, assembled into imem_rdata and returned with one resp pulse.
module ssrv_imem_wb_bridge #(
  parameter int BEATS          = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                imem_req,
  input  logic [31:0]         imem_addr,
  output logic [32*BEATS-1:0] imem_rdata,
  output logic                imem_resp,
  output logic                imem_err,
  output logic                core_cyc,
  output logic                core_stb,
  output logic                core_we,
  output logic [3:0]          core_sel,
  output logic [31:0]         core_addr,
  output logic [31:0]         core_data_out,
  input  logic [31:0]         core_data_in,
  input  logic                core_ack,
  input  logic                core_err
);
  localparam int BW = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, STB, WAIT, DONE} state_t;

  state_t                   state, state_nxt;
  logic [BW-1:0]            beat;
  logic [TMO_W-1:0]         tmo;
  logic                     err_flag;
  logic [BEATS-1:0][31:0]   line;
  logic                     bus_act, beat_ok, beat_err, tmo_hit, last_beat;
  logic                     unused_addr_lsb;

  assign unused_addr_lsb = ^imem_addr[3:0];

  assign bus_act   = (state == STB) || (state == WAIT);
  // err wins over a coincident ack, so the errored beat's data is never stored
  assign beat_err  = bus_act && core_err;
  assign beat_ok   = bus_act && core_ack && !core_err;
  assign last_beat = (beat == BW'(BEATS - 1));

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_tmo
      localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
      // fires on the TIMEOUT_CYCLES-th silent WAIT cycle of a beat
      assign tmo_hit = (state == WAIT) && !core_ack && !core_err && (tmo == TMO_LAST);
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end
  endgenerate

  assign imem_rdata    = line;
  assign core_we       = 1'b0;
  assign core_sel      = 4'hF;
  assign core_data_out = 32'h0;

  always_comb begin
    state_nxt = state;
    core_cyc  = 1'b0;
    core_stb  = 1'b0;
    imem_resp = 1'b0;
    imem_err  = 1'b0;
    case (state)
      IDLE: if (imem_req) state_nxt = STB;
      STB, WAIT: begin
        core_cyc = 1'b1;
        core_stb = (state == STB);
        if (beat_err || tmo_hit) state_nxt = DONE;
        else if (beat_ok)        state_nxt = last_beat ? DONE : STB;
        else                     state_nxt = WAIT;
      end
      DONE: begin
        imem_resp = 1'b1;
        imem_err  = err_flag;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      tmo       <= '0;
      err_flag  <= 1'b0;
      core_addr <= '0;
      line      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (imem_req) begin
          core_addr <= {imem_addr[31:4], 4'h0};
          line      <= '0;
          beat      <= '0;
          tmo       <= '0;
          err_flag  <= 1'b0;
        end
        STB, WAIT: begin
          if (beat_err || tmo_hit) begin
            err_flag <= 1'b1;
          end else if (beat_ok) begin
            line[beat] <= core_data_in;
            tmo        <= '0;
            if (!last_beat) begin
              beat      <= beat + BW'(1);
              core_addr <= core_addr + 32'd4;
            end
          end else if (state == WAIT) begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        DONE: begin
          err_flag <= 1'b0;
          tmo      <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ssrv_imem_wb_bridge.sv
// Bench for ssrv_imem_wb_bridge: table of line fetches driven through a cycle-level
// Wishbone slave, expected responses queued at request time and popped on imem_resp.
module tb_ssrv_imem_wb_bridge;
  localparam int TMO = 16;

  logic         sys_clk = 1'b0;
  logic         rst_n;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic [127:0] imem_rdata;
  logic         imem_resp, imem_err;
  logic         core_cyc, core_stb, core_we;
  logic [3:0]   core_sel;
  logic [31:0]  core_addr, core_data_out, core_data_in;
  logic         core_ack, core_err;

  ssrv_imem_wb_bridge #(.BEATS(4), .TIMEOUT_CYCLES(TMO), .TMO_W(8)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp), .imem_err(imem_err),
    .core_cyc(core_cyc), .core_stb(core_stb), .core_we(core_we), .core_sel(core_sel),
    .core_addr(core_addr), .core_data_out(core_data_out), .core_data_in(core_data_in),
    .core_ack(core_ack), .core_err(core_err)
  );

  always #5 sys_clk = ~sys_clk;

  // lat: cycles from strobe to ack; err_beat/tmo_beat: -1 for none
  typedef struct {
    logic [31:0]       addr;
    logic [3:0][31:0]  data;
    int                lat;
    int                err_beat;
    int                tmo_beat;
    logic [127:0]      exp_rdata;
    logic              exp_err;
    int                exp_lat;
  } vec_t;

  typedef struct {
    logic [127:0] rdata;
    logic         err;
    int           lat;
  } resp_t;

  resp_t       sb_q[$];
  logic [31:0] addr_q[$];
  int          n_pass = 0;
  int          n_tot  = 0;
  vec_t        vt[8];
  vec_t        v2000, h1, h2;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One fetch; hold keeps imem_req high through DONE, chained starts in the current cycle.
  task automatic run_vec(input vec_t v, input bit hold, input bit chained);
    int    c = 0, beat = 0, stb_c = -1, nstb = 0, nstop;
    bit    done = 0, cyc_ok = 1;
    resp_t r;
    if (!chained) @(negedge sys_clk);
    imem_req  = 1'b1;
    imem_addr = v.addr;
    nstop = (v.err_beat >= 0) ? v.err_beat + 1 : (v.tmo_beat >= 0) ? v.tmo_beat + 1 : 4;
    sb_q.push_back('{v.exp_rdata, v.exp_err, v.exp_lat});
    for (int b = 0; b < nstop; b++) addr_q.push_back({v.addr[31:4], 4'h0} + 32'(4 * b));
    @(posedge sys_clk);
    while (!done) begin
      @(negedge sys_clk);
      c++;
      if (!hold) imem_req = 1'b0;
      core_ack = 1'b0; core_err = 1'b0; core_data_in = $urandom;
      if (core_stb) begin
        nstb++;
        stb_c = c;
        if (addr_q.size() > 0) chk("stb_addr", 128'(core_addr), 128'(addr_q.pop_front()));
      end
      if (stb_c >= 0 && c == stb_c + v.lat && beat < 4) begin
        if (beat != v.tmo_beat) begin
          core_ack = 1'b1;
          core_data_in = v.data[beat];
          if (beat == v.err_beat) core_err = 1'b1;
        end
        beat++;
        stb_c = -1;
      end
      if (imem_resp) begin
        done = 1;
        r = sb_q.pop_front();
        chk("rdata", imem_rdata, r.rdata);
        chk("err", 128'(imem_err), 128'(r.err));
        chk("latency", 128'(c), 128'(r.lat));
        core_ack = 1'b1; core_err = 1'b1; core_data_in = 32'hDEAD_DEAD;
      end else if (!core_cyc) begin
        cyc_ok = 0;
      end
      if (!done && c > 200) begin
        done = 1;
        r = sb_q.pop_front();
        chk("resp_timeout", 128'(c), 128'(r.lat));
      end
    end
    chk("n_stb", 128'(nstb), 128'(nstop));
    chk("cyc_hold", 128'(cyc_ok), 128'(1));
    @(negedge sys_clk);
    core_ack = 1'b0; core_err = 1'b0;
    chk("resp_pulse", 128'({imem_resp, imem_err, core_cyc}), 128'(0));
    chk("rdata_hold", imem_rdata, v.exp_rdata);
    addr_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_n = 1'b0; imem_req = 1'b0; imem_addr = '0;
    core_data_in = '0; core_ack = 1'b0; core_err = 1'b0;

    vt[0] = '{32'h0000_1004, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 1, -1, -1,
              128'h44444444_33333333_22222222_11111111, 1'b0, 9};
    vt[1] = '{32'h0000_300C, {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0}, 1, 2, -1,
              128'h00000000_00000000_B1B1B1B1_A0A0A0A0, 1'b1, 7};
    vt[2] = '{32'h0000_4000, {4{32'h0BAD_0BAD}}, 1, -1, 0, 128'h0, 1'b1, 18};
    vt[3] = '{32'hFFFF_FFF0, {32'hCAFEF00D, 32'hDEADBEEF, 32'h89ABCDEF, 32'h01234567}, 0, -1, -1,
              128'hCAFEF00D_DEADBEEF_89ABCDEF_01234567, 1'b0, 5};
    vt[4] = '{32'h8000_001C, {32'h4, 32'h3, 32'h2, 32'h1}, 3, -1, -1,
              128'h00000004_00000003_00000002_00000001, 1'b0, 17};
    vt[5] = '{32'h0000_0050, {4{32'h5A5A_5A5A}}, 2, 0, -1, 128'h0, 1'b1, 4};
    vt[6] = '{32'h0000_0060, {32'h88, 32'h77, 32'h66, 32'h55}, 1, 3, -1,
              128'h00000000_00000077_00000066_00000055, 1'b1, 9};
    vt[7] = '{32'h0000_0100, {32'hCC, 32'hBB, 32'hAA, 32'h99}, 1, -1, 2,
              128'h00000000_00000000_000000AA_00000099, 1'b1, 22};
    v2000 = '{32'h0000_2000, {32'h2000000C, 32'h20000008, 32'h20000004, 32'h20000000}, 2, -1, -1,
              128'h2000000C_20000008_20000004_20000000, 1'b0, 13};
    h1    = '{32'h0000_6000, {32'h64646464, 32'h63636363, 32'h62626262, 32'h61616161}, 1, -1, -1,
              128'h64646464_63636363_62626262_61616161, 1'b0, 9};
    h2    = '{32'h0000_7010, {32'h74747474, 32'h73737373, 32'h72727272, 32'h71717171}, 0, -1, -1,
              128'h74747474_73737373_72727272_71717171, 1'b0, 5};

    #3;
    chk("rst_ctrl", 128'({core_cyc, core_stb, imem_resp, imem_err}), 128'(0));
    chk("rst_addr", 128'(core_addr), 128'(0));
    chk("rst_rdata", imem_rdata, 128'h0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    chk("const_bus", 128'({core_we, core_sel, core_data_out}), 128'({1'b0, 4'hF, 32'h0}));

    for (int i = 0; i < 8; i++) run_vec(vt[i], 1'b0, 1'b0);

    // reset during beat 1 WAIT
    @(negedge sys_clk); imem_req = 1'b1; imem_addr = 32'h0000_5000;
    @(posedge sys_clk);
    @(negedge sys_clk); imem_req = 1'b0;
    @(negedge sys_clk); core_ack = 1'b1; core_data_in = 32'h5555_0000;
    @(negedge sys_clk); core_ack = 1'b0;
    @(negedge sys_clk);
    chk("mid_cyc", 128'({core_cyc, core_stb}), 128'(2'b10));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cyc", 128'({core_cyc, core_stb}), 128'(0));
    chk("abort_addr", 128'(core_addr), 128'(0));
    chk("abort_rdata", imem_rdata, 128'h0);
    seen = 0;
    repeat (3) begin
      @(negedge sys_clk);
      if (imem_resp || core_cyc) seen = 1;
    end
    chk("abort_no_resp", 128'(seen), 128'(0));
    rst_n = 1'b1;
    run_vec(v2000, 1'b0, 1'b0);

    // spurious ack / err while idle
    core_ack = 1'b1; core_err = 1'b1; core_data_in = 32'hBADB_AD00;
    @(negedge sys_clk);
    chk("idle_ack_ctrl", 128'({core_cyc, imem_resp, imem_err}), 128'(0));
    chk("idle_ack_rdata", imem_rdata, v2000.exp_rdata);
    core_ack = 1'b0; core_err = 1'b0;

    // request held through DONE: exactly one follow-on fetch
    run_vec(h1, 1'b1, 1'b0);
    run_vec(h2, 1'b0, 1'b1);
    seen = 0;
    repeat (6) begin
      @(negedge sys_clk);
      if (core_cyc || core_stb || imem_resp) seen = 1;
    end
    chk("no_extra_fetch", 128'(seen), 128'(0));
    chk("sb_empty", 128'(sb_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
